// File: rtl/chess_move_controller.sv
// Button-driven move controller for the 8x8 board: debounces the push-buttons,
// steers the cursor, runs the source/destination selection and owns the piece map.
module chess_move_controller #(
    parameter int DB_SAMPLES   = 3,
    parameter int CURSOR_RESET = 52
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnC,
    input  logic [5:0] rd_tile,
    output logic [3:0] rd_piece,
    output logic [5:0] cursor_tile,
    output logic [5:0] src_tile,
    output logic       src_valid,
    output logic       turn,
    output logic       move_done,
    output logic       illegal
);

    localparam int CW = $clog2(DB_SAMPLES + 1);
    localparam int BR = 0;
    localparam int BL = 1;
    localparam int BD = 2;
    localparam int BU = 3;
    localparam int BC = 4;

    typedef enum logic [1:0] {SEL_SRC, SEL_DST, COMMIT, CLEAR} state_e;

    function automatic logic [3:0] init_piece(input logic [5:0] t);
        logic [2:0] ty;
        case (t[2:0])
            3'd0, 3'd7: ty = 3'd4;
            3'd1, 3'd6: ty = 3'd2;
            3'd2, 3'd5: ty = 3'd3;
            3'd3:       ty = 3'd5;
            default:    ty = 3'd6;
        endcase
        case (t[5:3])
            3'd0:    init_piece = {1'b1, ty};
            3'd1:    init_piece = 4'b1001;
            3'd6:    init_piece = 4'b0001;
            3'd7:    init_piece = {1'b0, ty};
            default: init_piece = 4'b0000;
        endcase
    endfunction

    logic [4:0]    raw;
    logic [4:0]    db_q;
    logic [4:0]    ev_q;
    logic [CW-1:0] cnt_q [5];

    assign raw = {btnC, btnU, btnD, btnL, btnR};

    // ev_q fires for exactly one cycle after the tick that raises a debounced level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q <= '0;
            ev_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            ev_q <= '0;
            if (sample_tick) begin
                for (int i = 0; i < 5; i++) begin
                    if (raw[i] == db_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == CW'(DB_SAMPLES - 1)) begin
                        cnt_q[i] <= '0;
                        db_q[i]  <= raw[i];
                        ev_q[i]  <= raw[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    state_e     state_q;
    logic [3:0] map_q [64];
    logic [5:0] cursor_q;
    logic [5:0] src_q;
    logic [5:0] dst_q;
    logic       src_valid_q;
    logic       turn_q;
    logic       move_done_q;
    logic       illegal_q;
    logic [3:0] cur_piece;
    logic       cur_own;

    assign cur_piece = map_q[cursor_q];
    assign cur_own   = (cur_piece[2:0] != 3'd0) && (cur_piece[3] == turn_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) map_q[i] <= init_piece(6'(i));
            state_q     <= SEL_SRC;
            cursor_q    <= 6'(CURSOR_RESET);
            src_q       <= '0;
            dst_q       <= '0;
            src_valid_q <= 1'b0;
            turn_q      <= 1'b0;
            move_done_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            move_done_q <= 1'b0;
            illegal_q   <= 1'b0;
            unique case (state_q)
                SEL_SRC, SEL_DST: begin
                    if (ev_q[BC]) begin
                        if (state_q == SEL_SRC) begin
                            if (cur_own) begin
                                src_q       <= cursor_q;
                                src_valid_q <= 1'b1;
                                state_q     <= SEL_DST;
                            end else begin
                                illegal_q <= 1'b1;
                            end
                        end else if (cursor_q == src_q) begin
                            src_valid_q <= 1'b0;
                            state_q     <= SEL_SRC;
                        end else if (cur_own) begin
                            src_q <= cursor_q;
                        end else begin
                            dst_q   <= cursor_q;
                            state_q <= COMMIT;
                        end
                    end else if (ev_q[BU]) begin
                        cursor_q <= {cursor_q[5:3] - 3'd1, cursor_q[2:0]};
                    end else if (ev_q[BD]) begin
                        cursor_q <= {cursor_q[5:3] + 3'd1, cursor_q[2:0]};
                    end else if (ev_q[BL]) begin
                        cursor_q <= {cursor_q[5:3], cursor_q[2:0] - 3'd1};
                    end else if (ev_q[BR]) begin
                        cursor_q <= {cursor_q[5:3], cursor_q[2:0] + 3'd1};
                    end
                end
                COMMIT: begin
                    map_q[dst_q] <= map_q[src_q];
                    move_done_q  <= 1'b1;
                    state_q      <= CLEAR;
                end
                CLEAR: begin
                    map_q[src_q] <= 4'd0;
                    src_valid_q  <= 1'b0;
                    turn_q       <= ~turn_q;
                    state_q      <= SEL_SRC;
                end
            endcase
        end
    end

    assign rd_piece    = map_q[rd_tile];
    assign cursor_tile = cursor_q;
    assign src_tile    = src_q;
    assign src_valid   = src_valid_q;
    assign turn        = turn_q;
    assign move_done   = move_done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_chess_move_controller.sv
// Directed bench for chess_move_controller: board reset, debounce, cursor wrap,
// move commit timing, illegal selection, reselect, mid-move reset, arbitration.
module tb_chess_move_controller;

    localparam int DB = 3;
    localparam logic [4:0] MC = 5'b10000;
    localparam logic [4:0] MU = 5'b01000;
    localparam logic [4:0] MD = 5'b00100;
    localparam logic [4:0] ML = 5'b00010;
    localparam logic [4:0] MR = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_tick = 1'b0;
    logic [4:0] btn = '0;
    logic [5:0] rd_tile = '0;
    logic [3:0] rd_piece;
    logic [5:0] cursor_tile;
    logic [5:0] src_tile;
    logic       src_valid;
    logic       turn;
    logic       move_done;
    logic       illegal;

    int nvec = 0;
    int nerr = 0;
    int md_cnt = 0;
    int il_cnt = 0;
    logic [3:0] exp_map [64];

    chess_move_controller #(.DB_SAMPLES(DB), .CURSOR_RESET(52)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .btnU(btn[3]), .btnD(btn[2]), .btnL(btn[1]), .btnR(btn[0]), .btnC(btn[4]),
        .rd_tile(rd_tile), .rd_piece(rd_piece),
        .cursor_tile(cursor_tile), .src_tile(src_tile), .src_valid(src_valid),
        .turn(turn), .move_done(move_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (move_done) md_cnt++;
        if (illegal) il_cnt++;
    end

    function automatic logic [3:0] start_piece(input int t);
        int row;
        int col;
        logic [2:0] ty;
        row = t / 8;
        col = t % 8;
        case (col)
            0, 7:    ty = 3'd4;
            1, 6:    ty = 3'd2;
            2, 5:    ty = 3'd3;
            3:       ty = 3'd5;
            default: ty = 3'd6;
        endcase
        if (row == 0)      return {1'b1, ty};
        else if (row == 1) return 4'b1001;
        else if (row == 6) return 4'b0001;
        else if (row == 7) return {1'b0, ty};
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 64; t++) exp_map[t] = start_piece(t);
    endtask

    task automatic tick();
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
    endtask

    task automatic press_ev(input logic [4:0] m);
        btn = m;
        repeat (DB) tick();
    endtask

    task automatic release_btn();
        btn = '0;
        repeat (DB) tick();
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] m);
        press_ev(m);
        release_btn();
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        nvec++;
        if (cursor_tile !== 6'd52) begin
            nerr++; $display("FAIL reset_cursor got %0d want 52", cursor_tile);
        end
        nvec++;
        if ({src_tile, src_valid, turn, move_done, illegal} !== 10'd0) begin
            nerr++;
            $display("FAIL reset_flags got src=%0d v=%b t=%b md=%b il=%b want 0",
                     src_tile, src_valid, turn, move_done, illegal);
        end
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        for (int t = 0; t < 64; t++) begin
            rd_tile = 6'(t); #1;
            nvec++;
            if (rd_piece !== exp_map[t]) begin
                nerr++; $display("FAIL reset_board[%0d] got %b want %b", t, rd_piece, exp_map[t]);
            end
        end
        rd_tile = 6'd4; #1; nvec++;
        if (rd_piece !== 4'b1110) begin
            nerr++; $display("FAIL tile4 got %b want 1110", rd_piece);
        end
        rd_tile = 6'd60; #1; nvec++;
        if (rd_piece !== 4'b0110) begin
            nerr++; $display("FAIL tile60 got %b want 0110", rd_piece);
        end
        rd_tile = 6'd20; #1; nvec++;
        if (rd_piece !== 4'b0000) begin
            nerr++; $display("FAIL tile20 got %b want 0000", rd_piece);
        end
    endtask

    task automatic test_debounce();
        press_ev(MU);
        repeat (DB) tick();
        release_btn();
        nvec++;
        if (cursor_tile !== 6'd44) begin
            nerr++; $display("FAIL hold_single_event got %0d want 44", cursor_tile);
        end
        btn = MU;
        tick();
        btn = '0;
        repeat (DB) tick();
        repeat (2) @(negedge clk);
        nvec++;
        if (cursor_tile !== 6'd44) begin
            nerr++; $display("FAIL glitch got %0d want 44", cursor_tile);
        end
        press(MD);
        nvec++;
        if (cursor_tile !== 6'd52) begin
            nerr++; $display("FAIL down got %0d want 52", cursor_tile);
        end
    endtask

    task automatic test_wrap();
        repeat (6) press(MU);
        nvec++;
        if (cursor_tile !== 6'd4) begin
            nerr++; $display("FAIL up_to_row0 got %0d want 4", cursor_tile);
        end
        press(MU);
        nvec++;
        if (cursor_tile !== 6'd60) begin
            nerr++; $display("FAIL up_wrap got %0d want 60", cursor_tile);
        end
        press(MD);
        nvec++;
        if (cursor_tile !== 6'd4) begin
            nerr++; $display("FAIL down_wrap got %0d want 4", cursor_tile);
        end
        repeat (3) press(MR);
        nvec++;
        if (cursor_tile !== 6'd7) begin
            nerr++; $display("FAIL right_to_7 got %0d want 7", cursor_tile);
        end
        press(MR);
        nvec++;
        if (cursor_tile !== 6'd0) begin
            nerr++; $display("FAIL right_wrap got %0d want 0", cursor_tile);
        end
        press(ML);
        nvec++;
        if (cursor_tile !== 6'd7) begin
            nerr++; $display("FAIL left_wrap got %0d want 7", cursor_tile);
        end
        press(MU);
        press(MU);
        repeat (4) press(ML);
        press(MD);
        nvec++;
        if (cursor_tile !== 6'd59) begin
            nerr++; $display("FAIL nav_back got %0d want 59", cursor_tile);
        end
        press(MU);
        press(MR);
        nvec++;
        if (cursor_tile !== 6'd52) begin
            nerr++; $display("FAIL return got %0d want 52", cursor_tile);
        end
    endtask

    task automatic test_move();
        int md0;
        press(MC);
        nvec++;
        if (src_valid !== 1'b1 || src_tile !== 6'd52) begin
            nerr++; $display("FAIL select_src got v=%b src=%0d want 1/52", src_valid, src_tile);
        end
        press(MU);
        press(MU);
        nvec++;
        if (cursor_tile !== 6'd36) begin
            nerr++; $display("FAIL cursor_36 got %0d want 36", cursor_tile);
        end
        md0 = md_cnt;
        press_ev(MC);
        @(negedge clk);
        rd_tile = 6'd36; #1; nvec++;
        if (move_done !== 1'b0 || rd_piece !== 4'b0000) begin
            nerr++; $display("FAIL commit_cycle got md=%b p36=%b want 0/0000", move_done, rd_piece);
        end
        @(negedge clk);
        rd_tile = 6'd36; #1; nvec++;
        if (move_done !== 1'b1 || rd_piece !== 4'b0001) begin
            nerr++; $display("FAIL dst_write got md=%b p36=%b want 1/0001", move_done, rd_piece);
        end
        rd_tile = 6'd52; #1; nvec++;
        if (rd_piece !== 4'b0001 || turn !== 1'b0) begin
            nerr++; $display("FAIL src_pending got p52=%b turn=%b want 0001/0", rd_piece, turn);
        end
        @(negedge clk);
        rd_tile = 6'd52; #1; nvec++;
        if (move_done !== 1'b0 || rd_piece !== 4'b0000 || turn !== 1'b1 || src_valid !== 1'b0) begin
            nerr++;
            $display("FAIL clear got md=%b p52=%b turn=%b v=%b want 0/0000/1/0",
                     move_done, rd_piece, turn, src_valid);
        end
        release_btn();
        nvec++;
        if (md_cnt - md0 !== 1) begin
            nerr++; $display("FAIL move_done_count got %0d want 1", md_cnt - md0);
        end
        exp_map[36] = 4'b0001;
        exp_map[52] = 4'b0000;
        for (int t = 0; t < 64; t++) begin
            rd_tile = 6'(t); #1;
            nvec++;
            if (rd_piece !== exp_map[t]) begin
                nerr++; $display("FAIL move_board[%0d] got %b want %b", t, rd_piece, exp_map[t]);
            end
        end
    endtask

    task automatic test_illegal();
        int il0;
        il0 = il_cnt;
        press_ev(MC);
        @(negedge clk);
        nvec++;
        if (illegal !== 1'b1) begin
            nerr++; $display("FAIL illegal_white got %b want 1", illegal);
        end
        @(negedge clk);
        nvec++;
        if (illegal !== 1'b0) begin
            nerr++; $display("FAIL illegal_one_cycle got %b want 0", illegal);
        end
        release_btn();
        press(MU);
        press(MC);
        nvec++;
        if (il_cnt - il0 !== 2 || src_valid !== 1'b0) begin
            nerr++; $display("FAIL illegal_count got %0d v=%b want 2/0", il_cnt - il0, src_valid);
        end
        for (int t = 0; t < 64; t++) begin
            rd_tile = 6'(t); #1;
            nvec++;
            if (rd_piece !== exp_map[t]) begin
                nerr++; $display("FAIL illegal_board[%0d] got %b want %b", t, rd_piece, exp_map[t]);
            end
        end
        press(MU);
        press(MU);
        press(MC);
        nvec++;
        if (src_valid !== 1'b1 || src_tile !== 6'd12) begin
            nerr++; $display("FAIL black_select got v=%b src=%0d want 1/12", src_valid, src_tile);
        end
    endtask

    task automatic test_reselect();
        int md0;
        int il0;
        pulse_reset();
        md0 = md_cnt;
        il0 = il_cnt;
        press(MC);
        press(ML);
        press(MC);
        nvec++;
        if (src_valid !== 1'b1 || src_tile !== 6'd51) begin
            nerr++; $display("FAIL reselect got v=%b src=%0d want 1/51", src_valid, src_tile);
        end
        press(MC);
        nvec++;
        if (src_valid !== 1'b0) begin
            nerr++; $display("FAIL deselect got v=%b want 0", src_valid);
        end
        nvec++;
        if (md_cnt - md0 !== 0 || il_cnt - il0 !== 0) begin
            nerr++; $display("FAIL reselect_pulses got md=%0d il=%0d want 0/0", md_cnt - md0, il_cnt - il0);
        end
        rd_tile = 6'd51; #1; nvec++;
        if (rd_piece !== 4'b0001) begin
            nerr++; $display("FAIL reselect_p51 got %b want 0001", rd_piece);
        end
        rd_tile = 6'd52; #1; nvec++;
        if (rd_piece !== 4'b0001) begin
            nerr++; $display("FAIL reselect_p52 got %b want 0001", rd_piece);
        end
    endtask

    task automatic test_reset_commit();
        int md0;
        pulse_reset();
        md0 = md_cnt;
        press(MC);
        press(MU);
        press_ev(MC);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        for (int t = 0; t < 64; t++) begin
            rd_tile = 6'(t); #1;
            nvec++;
            if (rd_piece !== exp_map[t]) begin
                nerr++; $display("FAIL rst_commit_board[%0d] got %b want %b", t, rd_piece, exp_map[t]);
            end
        end
        nvec++;
        if (turn !== 1'b0 || src_valid !== 1'b0 || cursor_tile !== 6'd52 || move_done !== 1'b0) begin
            nerr++;
            $display("FAIL rst_commit_state got t=%b v=%b cur=%0d md=%b want 0/0/52/0",
                     turn, src_valid, cursor_tile, move_done);
        end
        btn = '0;
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
        nvec++;
        if (md_cnt - md0 !== 0) begin
            nerr++; $display("FAIL rst_commit_md got %0d want 0", md_cnt - md0);
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        press(MC | MU);
        nvec++;
        if (src_valid !== 1'b1 || src_tile !== 6'd52 || cursor_tile !== 6'd52) begin
            nerr++;
            $display("FAIL arbitration got v=%b src=%0d cur=%0d want 1/52/52",
                     src_valid, src_tile, cursor_tile);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_wrap();
        test_move();
        test_illegal();
        test_reselect();
        test_reset_commit();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
